pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational adder.
- Adds two WIDTH-bit operands plus carry-in. The carry chain is split into SEG_W-bit segments, with one segment resolved per pipeline stage.
- Valid/ready handshake on both sides. Sits between operand sources and result consumers in datapath blocks that need wide adds at high clock rate.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be an integer multiple of SEG_W.
- SEG_W, 4, bits resolved per pipeline stage; NSEG = WIDTH/SEG_W stages (derived, not overridable).

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat offered
- in_ready  output  1  pipeline can accept a beat this cycle
- A  input  WIDTH  operand A (unsigned or two's complement)
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- out_valid  output  1  result beat available
- out_ready  input  1  consumer accepts result this cycle
- Sum  output  WIDTH  A+B+Cin modulo 2^WIDTH
- Cout  output  1  unsigned carry-out
- Ovf  output  1  signed overflow: carry into MSB XOR Cout

Behaviour:
- Reset, asynchronous on rst high:
  - all stage valid bits, out_valid, Sum, Cout and Ovf go to 0; in-flight beats are discarded.
  - in_ready = 1 while rst is high and after release.
- Pipeline:
  - NSEG register stages, each holding a valid bit, the resolved low sum segments, the carry, and the not-yet-added upper operand segments.
  - Stage k (0-based) adds segment k of A/B plus the carry from stage k-1 (Cin for k=0). Lower result segments are carried forward unchanged; upper operand segments are delayed.
- Latency: a beat accepted on edge N (in_valid & in_ready) presents out_valid=1 with its full result after edge N+NSEG-1 if no stall occurs, i.e. NSEG cycles of register delay (4 for defaults).
- Throughput: one beat per cycle when out_ready stays high.
- Stall:
  - Global enable: adv = !out_valid | out_ready.
  - When adv=0, every stage holds and in_ready=0.
  - Bubbles are not collapsed; in_ready = adv.
- Acceptance: a beat is taken only when in_valid & in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Output hold: while out_valid=1 and out_ready=0, Sum/Cout/Ovf/out_valid stay stable.
- Simultaneous events: out_ready=1 with the last stage valid and a new beat on input in the same cycle means the result is consumed and the new beat enters. No loss or duplication.
- Ordering: results leave strictly in acceptance order.
- Arithmetic:
  - Sum = (A+B+Cin) mod 2^WIDTH; Cout = bit WIDTH of the full sum.
  - Ovf = (A[MSB]==B[MSB]) & (Sum[MSB]!=A[MSB]), equivalent to carry-into-MSB XOR Cout.
- Degenerate case: SEG_W=WIDTH gives a single-stage registered adder with the same handshake.
- Input operands need only be stable during the accepting cycle.

Decomposition:
- Shared package: none required. Derived localparam NSEG stays local. Add a compile-time check (generate-time error) for WIDTH % SEG_W != 0.
- One sub-module, adder_seg: combinational SEG_W-bit add of a, b, cin -> s, cout, plus carry-into-MSB output for the overflow tap. Instantiated NSEG times in a generate loop; pipeline registers stay in pipe_adder.

Test Plan:
Bench uses defaults WIDTH=16, SEG_W=4, out_ready=1 unless stated.
- Basic: A=0x0001, B=0x0002, Cin=0 -> 4 cycles later out_valid=1, Sum=0x0003, Cout=0, Ovf=0.
- Full carry ripple across all segments: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. Also A=0xAAAA, B=0x5555, Cin=1 -> Sum=0x0000, Cout=1.
- Signed overflow: A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1. A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1.
- Back-to-back plus stall:
  - Stimulus: 8 consecutive beats (A=i, B=0x1000*i, Cin=i[0]); drop out_ready for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall; Sum/Cout held stable; all 8 results appear in order with none lost or duplicated; throughput returns to 1/cycle afterwards.
- Reset mid-operation: assert rst asynchronously (between edges) with 3 beats in flight -> out_valid=0 and Sum=0 immediately; after release in_ready=1 and no stale results appear. A new beat A=0x1234, B=0x4321 -> Sum=0x5555.
- Random: 1000 beats with random in_valid/out_ready compared against a reference model of A+B+Cin, in both the default and the SEG_W=16 configurations.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared helpers for the segmented pipelined adder.
package pipe_adder_pkg;

    // Signed overflow of a two's complement add: carry into the MSB differs from carry out.
    function automatic logic f_signed_ovf(input logic c_into_msb, input logic c_out);
        return c_into_msb ^ c_out;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: combinational SEG_W-bit add with carry-in, carry-out and the
// carry into the segment MSB (used as the signed-overflow tap on the top segment).
module adder_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SEG_W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    assign s      = w_full[SEG_W-1:0];
    assign cout   = w_full[SEG_W];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum bit.
    assign c_msb  = a[SEG_W-1] ^ b[SEG_W-1] ^ w_full[SEG_W-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder whose carry chain is cut into SEG_W-bit segments,
// one segment resolved per register stage, with a valid/ready handshake and a
// single global advance enable (bubbles are kept, not collapsed).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSEG = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0) begin : g_width_check
        $error("pipe_adder: WIDTH must be an integer multiple of SEG_W");
    end

    logic w_adv;
    logic w_last_valid;

    // The whole pipeline moves together unless a held result blocks the output.
    assign w_adv    = !w_last_valid | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic             r_valid;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_sum;
        logic             r_carry;
        logic             r_ovf;

        logic             w_valid_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
        logic             w_carry_in;
        logic [WIDTH-1:0] w_sum_next;
        logic [SEG_W-1:0] w_seg_sum;
        logic             w_seg_cout;
        logic             w_seg_cmsb;
        logic             w_unused_ab;

        if (k == 0) begin : g_src
            assign w_valid_in = in_valid;
            assign w_a_in     = A;
            assign w_b_in     = B;
            assign w_sum_in   = {WIDTH{1'b0}};
            assign w_carry_in = Cin;
        end else begin : g_src
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_a_in     = g_stage[k-1].r_a;
            assign w_b_in     = g_stage[k-1].r_b;
            assign w_sum_in   = g_stage[k-1].r_sum;
            assign w_carry_in = g_stage[k-1].r_carry;
        end

        adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (w_a_in[k*SEG_W +: SEG_W]),
            .b     (w_b_in[k*SEG_W +: SEG_W]),
            .cin   (w_carry_in),
            .s     (w_seg_sum),
            .cout  (w_seg_cout),
            .c_msb (w_seg_cmsb)
        );

        // Merge this stage's resolved segment into the partial sum carried forward.
        always_comb begin
            w_sum_next                      = w_sum_in;
            w_sum_next[k*SEG_W +: SEG_W]    = w_seg_sum;
        end

        // Stage register: captures valid, partial sum, carry and the operands on advance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_a     <= {WIDTH{1'b0}};
                r_b     <= {WIDTH{1'b0}};
                r_sum   <= {WIDTH{1'b0}};
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_valid_in;
                r_a     <= w_a_in;
                r_b     <= w_b_in;
                r_sum   <= w_sum_next;
                r_carry <= w_seg_cout;
                r_ovf   <= f_signed_ovf(w_seg_cmsb, w_seg_cout);
            end
        end

        // Operand copies of the last stage and overflow of inner stages are never consumed.
        assign w_unused_ab = ^{r_a, r_b, r_ovf};
    end

    assign w_last_valid = g_stage[NSEG-1].r_valid;
    assign out_valid    = g_stage[NSEG-1].r_valid;
    assign Sum          = g_stage[NSEG-1].r_sum;
    assign Cout         = g_stage[NSEG-1].r_carry;
    assign Ovf          = g_stage[NSEG-1].r_ovf;

endmodule
